tach_sampler: RTL
=================

// Module: tach_sampler
// PURPOSE
//  Sequences the 16-bit quadrature tach counter for periodic velocity measurement.
//  Generates the filter clock-enable, runs a programmable sample timer, freezes the counter,
//  snapshots {counth,countl}, and computes the signed delta since the previous snapshot.
//  Results go to the host/control loop through a valid/ack handshake with overrun flag.
//  Sits between tachcounter (filterce/freeze/counth/countl) and the motor-control register file.
// PARAMETERS
//  FILT_DIV   16   filterce strobe period in clk cycles (>=2)
//  PERIOD_W   16   width of period input / sample timer
// PORTS
//  clk       in   1         system clock, all logic on posedge
//  reset     in   1         asynchronous, active-high reset
//  enable    in   1         1 = run periodic sampling
//  period    in   PERIOD_W  sample interval in clk cycles; values 0..3 treated as 4
//  countl    in   8         tach counter low byte
//  counth    in   8         tach counter high byte
//  ack       in   1         host consumed current sample (single-cycle pulse)
//  filterce  out  1         one-clk strobe every FILT_DIV clocks to digital filters
//  freeze    out  1         holds quadrature decoder during snapshot
//  position  out  16        snapshot {counth,countl}
//  velocity  out  16        position - previous position, two's complement, mod 2^16
//  valid     out  1         new sample available; sticky until ack
//  overrun   out  1         sample replaced while valid and unacked; sticky until ack
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; prescaler, timer, prev, primed cleared.
//  filterce: free-running prescaler, independent of enable; pulses 1 clk when prescaler
//   reaches FILT_DIV-1, then wraps to 0. First pulse FILT_DIV clocks after reset release.
//  FSM states IDLE, COUNT, FREEZE, SETTLE, CAPTURE:
//   IDLE: freeze=0; primed=0; enable=1 -> COUNT, timer <= max(period,4)-4.
//   COUNT: timer decrements each clk; enable=0 -> IDLE; timer==0 -> FREEZE.
//   FREEZE: freeze=1 (1 clk) -> SETTLE. Lets the decoder's registered up/down pulse land.
//   SETTLE: freeze=1 (1 clk) -> CAPTURE. Counter now stable.
//   CAPTURE: freeze=1; at clk edge: cur={counth,countl}; prev<=cur; position<=cur;
//    if primed: velocity<=cur-prev (16-bit wrap), valid<=1; else primed<=1 only.
//    Next: enable ? COUNT (timer reloaded from period sampled now) : IDLE.
//  freeze registered output; high exactly 3 clks per sample; sample-to-sample spacing
//   = max(period,4) clocks exactly. period changes take effect at next reload.
//  Frozen edges are not lost: decoder keeps its last state and counts the edge after release.
//  enable falling in FREEZE/SETTLE/CAPTURE: sequence completes (capture happens), then IDLE.
//  Re-enable after IDLE: first capture primes only (no valid); valid from second capture on.
//  Handshake: ack with valid=1 clears valid and overrun. ack with valid=0 ignored.
//  Capture while valid=1 and no ack that cycle: data replaced, valid stays 1, overrun<=1.
//  Capture and ack same cycle: new data loaded, valid=1, overrun<=0 (old sample was consumed).
//  Velocity is pure 16-bit subtraction: no saturation; counter wrap yields correct small delta.
//  Reset asserted mid-sequence: freeze drops immediately (async), no capture, no valid.
// TESTING
//  1 Reset then FILT_DIV=16 -> filterce 1-clk pulses at cycles 16,32,48 after release; freeze=0.
//  2 enable=1, period=100, counter +7 per interval -> first capture no valid; then valid
//    every 100 clks, velocity=0x0007, freeze high 3 clks each sample, counter held meanwhile.
//  3 Wrap: prev=0xFFFE, cur=0x0003 -> velocity=0x0005; prev=0x0002, cur=0xFFFF -> 0xFFFD.
//  4 No ack over two captures -> overrun=1, position=newer; ack -> valid=0, overrun=0;
//    ack coincident with capture -> valid=1, overrun=0, new data.
//  5 Deassert enable during SETTLE -> capture completes, FSM IDLE, freeze=0; re-enable ->
//    next capture primes only, no valid pulse.
//  6 Assert reset during FREEZE -> freeze, valid, outputs 0 same cycle; period=2 -> 4-clk interval.

Source files
------------

// File: rtl/tach_sampler.sv
// tach_sampler: filter strobe, periodic freeze/snapshot of the tach counter, signed delta, valid/ack handshake.
module tach_sampler #(
  parameter int FILT_DIV = 16,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          countl,
  input  logic [7:0]          counth,
  input  logic                ack,
  output logic                filterce,
  output logic                freeze,
  output logic [15:0]         position,
  output logic [15:0]         velocity,
  output logic                valid,
  output logic                overrun
);
  localparam int PW = $clog2(FILT_DIV);
  typedef enum logic [2:0] {IDLE, COUNT, FRZ, SETTLE, CAPTURE} state_t;
  state_t state, next;
  logic [PW-1:0] pre;
  logic [PERIOD_W-1:0] timer, reload;
  logic [15:0] cur, prev;
  logic primed, cap, freeze_d;
  assign reload = (period < PERIOD_W'(4)) ? '0 : period - PERIOD_W'(4);
  assign cur = {counth, countl};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre <= '0;
      filterce <= 1'b0;
    end else begin
      pre <= (pre == PW'(FILT_DIV - 1)) ? '0 : pre + 1'b1;
      filterce <= (pre == PW'(FILT_DIV - 1));
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= next;
      timer <= (next == COUNT && state != COUNT) ? reload : (state == COUNT) ? timer - 1'b1 : timer;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = enable ? COUNT : IDLE;
      COUNT:   next = !enable ? IDLE : (timer == '0) ? FRZ : COUNT;
      FRZ:     next = SETTLE;
      SETTLE:  next = CAPTURE;
      CAPTURE: next = enable ? COUNT : IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    freeze_d = (next == FRZ) || (next == SETTLE) || (next == CAPTURE);
    cap = (state == CAPTURE);
  end
  // freeze is registered from next-state so it is glitch-free toward the decoder
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      freeze <= 1'b0;
      primed <= 1'b0;
      prev <= '0;
      position <= '0;
      velocity <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      freeze <= freeze_d;
      primed <= (state == IDLE) ? 1'b0 : cap ? 1'b1 : primed;
      if (cap) begin
        prev <= cur;
        position <= cur;
      end
      if (cap && primed) begin
        velocity <= cur - prev;
        valid <= 1'b1;
        overrun <= valid && !ack;
      end else if (ack) begin
        valid <= 1'b0;
        overrun <= 1'b0;
      end
    end
endmodule
